// File: rtl/spi_host_master.sv
// spi_host_master: SPI mode-0 initiator, one DATA_WIDTH word per valid/ready handshake, CS held low across bursts
// Ports: CLK/RSTN clock and async active-low reset; i_valid/o_ready/i_data/i_last transmit handshake;
//        o_rx_valid/o_rx_data received word; o_busy activity flag; SCLK/CS/MOSI/MISO SPI pins.
// Build option: define SPIM_LSB_FIRST_EN to shift LSB first in both directions (default MSB first).
module spi_host_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_rx_valid,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  SCLK,
  output logic                  CS,
  output logic                  MOSI,
  input  logic                  MISO
);
  localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, DONE, CS_HOLD} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bit_cnt;
  logic [DATA_WIDTH-1:0] tx, rx, tx_next, rx_next;
  logic last_q, cnt_end, first_bit, next_bit, final_bit;
  assign cnt_end   = cnt == CW'(CLK_DIV - 1);
  assign final_bit = bit_cnt == BW'(DATA_WIDTH - 1);
`ifdef SPIM_LSB_FIRST_EN
  assign first_bit = i_data[0];
  assign next_bit  = tx[1];
  assign tx_next   = {1'b0, tx[DATA_WIDTH-1:1]};
  assign rx_next   = {MISO, rx[DATA_WIDTH-1:1]};
`else
  assign first_bit = i_data[DATA_WIDTH-1];
  assign next_bit  = tx[DATA_WIDTH-2];
  assign tx_next   = {tx[DATA_WIDTH-2:0], 1'b0};
  assign rx_next   = {rx[DATA_WIDTH-2:0], MISO};
`endif
  assign o_ready = state == IDLE;
  assign o_busy  = state != IDLE || !CS;
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      tx         <= '0;
      rx         <= '0;
      last_q     <= 1'b0;
      SCLK       <= 1'b0;
      CS         <= 1'b1;
      MOSI       <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
    end else begin
      o_rx_valid <= 1'b0;
      cnt        <= (state == IDLE || state == DONE || cnt_end) ? '0 : cnt + CW'(1);
      case (state)
        IDLE: if (i_valid) begin
          state   <= SETUP;
          CS      <= 1'b0;
          MOSI    <= first_bit;
          tx      <= i_data;
          last_q  <= i_last;
          bit_cnt <= '0;
        end
        SETUP: if (cnt_end) begin
          state <= HIGH;
          SCLK  <= 1'b1;
          rx    <= rx_next;
        end
        HIGH: if (cnt_end) begin
          state <= LOW;
          SCLK  <= 1'b0;
          if (!final_bit) begin
            tx   <= tx_next;
            MOSI <= next_bit;
          end
        end
        LOW: if (cnt_end) begin
          if (final_bit) begin
            state      <= DONE;
            o_rx_valid <= 1'b1;
            o_rx_data  <= rx;
          end else begin
            state   <= HIGH;
            SCLK    <= 1'b1;
            rx      <= rx_next;
            bit_cnt <= bit_cnt + BW'(1);
          end
        end
        DONE: begin
          state <= last_q ? CS_HOLD : IDLE;
          MOSI  <= 1'b0;
        end
        CS_HOLD: if (cnt_end) begin
          CS    <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_host_master.sv
// tb_spi_host_master: directed vector bench for spi_host_master with a mode-0 responder model
module tb_spi_host_master;
  logic CLK = 1'b0, RSTN = 1'b0;
  always #5 CLK = ~CLK;
  logic v0 = 1'b0, l0 = 1'b0, rdy0, rxv0, busy0, sclk0, cs0, mosi0, miso0;
  logic [7:0] d0 = '0, rxd0, pat0 = '0;
  logic v1 = 1'b0, l1 = 1'b0, rdy1, rxv1, busy1, sclk1, cs1, mosi1, miso1;
  logic [15:0] d1 = '0, rxd1, pat1 = '0, cap0 = '0, cap1 = '0;
  int pass_n = 0, total_n = 0;
  int sc0 = 0, base0 = 0, sc1 = 0, base1 = 0, rxcnt0 = 0, csr0 = 0;
  longint tl1 = 0, tp1 = 0;
  spi_host_master u0 (.CLK(CLK), .RSTN(RSTN), .i_valid(v0), .o_ready(rdy0), .i_data(d0), .i_last(l0),
    .o_rx_valid(rxv0), .o_rx_data(rxd0), .o_busy(busy0), .SCLK(sclk0), .CS(cs0), .MOSI(mosi0), .MISO(miso0));
  spi_host_master #(.DATA_WIDTH(16), .CLK_DIV(1)) u1 (.CLK(CLK), .RSTN(RSTN), .i_valid(v1), .o_ready(rdy1),
    .i_data(d1), .i_last(l1), .o_rx_valid(rxv1), .o_rx_data(rxd1), .o_busy(busy1), .SCLK(sclk1), .CS(cs1),
    .MOSI(mosi1), .MISO(miso1));
  function automatic logic sbit(input logic [15:0] p, input int w, input int i);
    if (i < 0 || i >= w) return 1'b0;
`ifdef SPIM_LSB_FIRST_EN
    return p[i];
`else
    return p[w-1-i];
`endif
  endfunction
  function automatic logic [15:0] ord(input logic [15:0] x, input int w);
    logic [15:0] r;
    r = x;
`ifdef SPIM_LSB_FIRST_EN
    r = '0;
    for (int i = 0; i < w; i++) r[w-1-i] = x[i];
`endif
    return r;
  endfunction
  assign miso0 = sbit({8'h00, pat0}, 8, sc0 - base0);
  assign miso1 = sbit(pat1, 16, sc1 - base1);
  always @(posedge sclk0) begin
    sc0  <= sc0 + 1;
    cap0 <= {cap0[14:0], mosi0};
  end
  always @(posedge sclk1) begin
    sc1  <= sc1 + 1;
    cap1 <= {cap1[14:0], mosi1};
    tp1  <= tl1;
    tl1  <= $time;
  end
  always @(posedge CLK) if (rxv0) rxcnt0 <= rxcnt0 + 1;
  always @(posedge cs0) csr0 <= csr0 + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %0h want %0h", n, a, e);
  endtask
  task automatic word0(input logic [7:0] d, input logic l, input logic [7:0] p, input string tag);
    int n;
    pat0 = p;
    @(negedge CLK);
    v0 = 1'b1; d0 = d; l0 = l;
    n = 0;
    while (!rdy0 && n < 200) begin @(negedge CLK); n++; end
    @(posedge CLK);
    #1 v0 = 1'b0; d0 = ~d; l0 = ~l; base0 = sc0;
    n = 0;
    do begin @(posedge CLK); n++; @(negedge CLK); end while (!rxv0 && n < 300);
    chk({tag, " latency"}, n, 68);
    chk({tag, " rx_data"}, rxd0, p);
    chk({tag, " mosi"}, cap0[7:0], ord({8'h00, d}, 8));
    chk({tag, " sclk_edges"}, sc0 - base0, 8);
    @(negedge CLK);
    chk({tag, " rx_pulse"}, rxv0, 0);
    if (l) begin
      repeat (3) @(negedge CLK);
      chk({tag, " cs_hold"}, cs0, 0);
      @(negedge CLK);
      chk({tag, " cs_rise"}, cs0, 1);
    end else begin
      chk({tag, " ready_after_done"}, {rdy0, cs0}, 2'b10);
    end
  endtask
  typedef struct {logic [7:0] d; logic l; logic [7:0] p; string tag;} vec_t;
  vec_t vt[5];
  initial begin
    int n, s0, c0, r0;
    logic ok;
    #400000 $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n, s0, c0, r0;
    logic ok;
    vt[0] = '{8'hA5, 1'b1, 8'h3C, "single"};
    vt[1] = '{8'h01, 1'b0, 8'h5A, "burst0"};
    vt[2] = '{8'h02, 1'b0, 8'hC3, "burst1"};
    vt[3] = '{8'h03, 1'b1, 8'h96, "burst2"};
    vt[4] = '{8'h01, 1'b1, 8'h01, "bitorder"};
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    ok = 1'b1;
    repeat (100) begin
      @(negedge CLK);
      if ({sclk0, cs0, mosi0, rdy0, busy0} !== 5'b01010) ok = 1'b0;
    end
    chk("idle sclk", sclk0, 0);
    chk("idle cs", cs0, 1);
    chk("idle mosi", mosi0, 0);
    chk("idle ready", rdy0, 1);
    chk("idle busy", busy0, 0);
    chk("idle stable", ok, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin s0 = sc0; c0 = csr0; r0 = rxcnt0; end
      word0(vt[i].d, vt[i].l, vt[i].p, vt[i].tag);
      if (i == 3) begin
        chk("burst sclk_edges", sc0 - s0, 24);
        chk("burst cs_rises", csr0 - c0, 1);
        chk("burst rx_pulses", rxcnt0 - r0, 3);
      end
    end
    pat0 = 8'h00;
    @(negedge CLK);
    v0 = 1'b1; d0 = 8'hFF; l0 = 1'b1;
    @(posedge CLK);
    #1 v0 = 1'b0; base0 = sc0; r0 = rxcnt0;
    n = 0;
    while (sc0 - base0 < 4 && n < 200) begin @(negedge CLK); n++; end
    @(negedge CLK);
    RSTN = 1'b0;
    #1;
    chk("rst sclk", sclk0, 0);
    chk("rst cs", cs0, 1);
    chk("rst mosi", mosi0, 0);
    chk("rst rx_valid", rxv0, 0);
    chk("rst rx_data", rxd0, 0);
    chk("rst busy", busy0, 0);
    chk("rst ready", rdy0, 1);
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;
    repeat (100) @(negedge CLK);
    chk("rst no_rx_valid", rxcnt0 - r0, 0);
    word0(8'h81, 1'b1, 8'h7E, "post_rst");
    pat1 = 16'h1234;
    @(negedge CLK);
    v1 = 1'b1; d1 = 16'hBEEF; l1 = 1'b1;
    n = 0;
    while (!rdy1 && n < 200) begin @(negedge CLK); n++; end
    @(posedge CLK);
    #1 v1 = 1'b0; d1 = 16'h0000; base1 = sc1;
    n = 0;
    do begin @(posedge CLK); n++; @(negedge CLK); end while (!rxv1 && n < 300);
    chk("w16 latency", n, 33);
    chk("w16 rx_data", rxd1, 16'h1234);
    chk("w16 mosi", cap1, ord(16'hBEEF, 16));
    chk("w16 sclk_edges", sc1 - base1, 16);
    chk("w16 sclk_period", 32'(tl1 - tp1), 20);
    repeat (5) @(negedge CLK);
    chk("w16 cs_rise", cs1, 1);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule

// File: doc/spi_host_master.md
Name: spi_host_master

Overview:
- SPI initiator (mode 0: CPOL=0, CPHA=0) that drives SCLK/CS/MOSI and samples MISO.
- Pairs with the core's SPI responder port: used by the bench host model and by board-level loaders to push program/data words into core memory and read responses back.
- Accepts one DATA_WIDTH word per valid/ready handshake and returns the simultaneously received word.
- CS is held low across a multi-word burst until a word tagged last completes.

Parameters:
- DATA_WIDTH, 8: bits per transfer word; must be ≥ 2.
- CLK_DIV, 4: CLK cycles per SCLK half-period; must be ≥ 1.

Ports:
- CLK  input  1  system clock.
- RSTN  input  1  asynchronous active-low reset.
- i_valid  input  1  transmit word offered.
- o_ready  output  1  block can accept a word this cycle.
- i_data  input  DATA_WIDTH  word to transmit.
- i_last  input  1  deassert CS after this word.
- o_rx_valid  output  1  one-cycle pulse: o_rx_data is valid.
- o_rx_data  output  DATA_WIDTH  word received on MISO.
- o_busy  output  1  transfer in progress, or CS held low.
- SCLK  output  1  SPI clock, idles 0.
- CS  output  1  chip select, active low.
- MOSI  output  1  serial data out.
- MISO  input  1  serial data in; sampled on SCLK rising edge.

Behaviour:
- Clock and reset: one clock, CLK. RSTN is asynchronous, active-low.
- Reset state, immediate on RSTN low and regardless of the current state:
  - SCLK=0, CS=1, MOSI=0, o_rx_valid=0, o_rx_data=0, o_busy=0, state=IDLE.
  - o_ready=1 after reset.
- A reset mid-transfer aborts the word. No o_rx_valid is produced for it.
- Handshake:
  - A word is accepted when i_valid && o_ready at a CLK edge.
  - i_data and i_last are captured at that edge. Later changes to either are ignored.
  - o_ready=1 only in IDLE.
- Bit order is MSB first (see Optional Feature).
- Divider: one counter counts 0..CLK_DIV-1 and each phase lasts exactly CLK_DIV cycles.
- States:
  - IDLE: SCLK=0; CS keeps its prior value; MOSI=0. On accept go to SETUP, with CS=0 and MOSI=first bit, both driven from the accept edge.
  - SETUP: lasts CLK_DIV cycles, then HIGH.
  - HIGH: SCLK=1. MISO is shifted into the rx shift register on the edge entering HIGH. Lasts CLK_DIV cycles, then LOW.
  - LOW: SCLK=0. On entry, MOSI advances to the next bit; after the final bit MOSI holds. Lasts CLK_DIV cycles. Then go to HIGH if bits remain, otherwise DONE.
  - DONE: one cycle. o_rx_valid=1 and o_rx_data=received word; o_rx_data holds until the next DONE. If the captured last flag is 1 go to CS_HOLD, otherwise go to IDLE with CS left at 0.
  - CS_HOLD: CS=0 for CLK_DIV cycles, then CS=1 and go to IDLE.
- Word latency: accept edge to o_rx_valid = CLK_DIV*(1+2*DATA_WIDTH) cycles. With defaults this is 68 cycles.
- Back-to-back words (last=0): o_ready is 1 in the cycle after DONE. The next word restarts at SETUP with CS kept low.
- o_busy = (state != IDLE) || (CS == 0).
- i_valid while not ready: the word is not consumed. i_valid asserted in the same cycle as DONE is accepted on the following cycle.
- SCLK, CS and MOSI are all driven from registers, so there are no combinational glitches.

Optional Feature:
- Macro: SPIM_LSB_FIRST_EN.
- When defined: transmit bit 0 first and shift the rx register so the first MISO bit lands in bit 0.
- When undefined: MSB first in both directions.
- Latency and the handshake are identical in both builds.

Test Plan:
- Reset idle (defaults): after reset release → SCLK=0, CS=1, MOSI=0, o_ready=1, o_busy=0, and these values are stable for 100 cycles.
- Single word, echo slave model: i_data=8'hA5, i_last=1 → MOSI sequence 1,0,1,0,0,1,0,1 on SCLK rising edges.
  - The slave returns 8'h3C, giving o_rx_data=8'h3C with o_rx_valid pulsed at accept+68.
  - CS returns high 4 cycles after DONE, and exactly 8 SCLK rising edges occur.
- Burst: words 8'h01 (last=0), 8'h02 (last=0), 8'h03 (last=1) → CS stays low across all three, with 24 SCLK rising edges total and three o_rx_valid pulses. CS rises only after the third word.
- Reset mid-operation: assert RSTN low during bit 3 of 8'hFF → outputs return to reset values in the same cycle and no o_rx_valid occurs. A following word 8'h81 transfers correctly.
- CLK_DIV=1, DATA_WIDTH=16: 16'hBEEF → SCLK period is 2 CLK cycles, latency is 33 cycles, and o_rx_data equals the 16-bit slave pattern 16'h1234.
- SPIM_LSB_FIRST_EN defined: i_data=8'h01 → MOSI is 1 on the first rising edge, then 0. Slave bits 1,0,0,0,0,0,0,0 yield o_rx_data=8'h01.
